// File: rtl/nbit_shift_register_if.sv
// Handshake and data bundle for nbit_shift_register.
// master drives data/mode/sin/start/amt (and rot if ROTATE_EN); slave returns q/sout/busy/done.
interface nbit_shift_register_if #(
  parameter int N  = 8,
  parameter int AW = 4
);
  logic [N-1:0]  data;
  logic [1:0]    mode;
  logic          sin;
  logic          start;
  logic [AW-1:0] amt;
`ifdef ROTATE_EN
  logic          rot;
`endif
  logic [N-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic          busy;
  logic          done;

`ifdef ROTATE_EN
  modport master (
    output data, mode, sin, start, amt, rot,
    input  q, sout_r, sout_l, busy, done
  );
  modport slave (
    input  data, mode, sin, start, amt, rot,
    output q, sout_r, sout_l, busy, done
  );
`else
  modport master (
    output data, mode, sin, start, amt,
    input  q, sout_r, sout_l, busy, done
  );
  modport slave (
    input  data, mode, sin, start, amt,
    output q, sout_r, sout_l, busy, done
  );
`endif
endinterface

// File: rtl/nbit_shift_register.sv
// N-bit shift register: hold/shift/load per edge, plus multi-cycle shift sequences.
// Ports: clk, rst (sync, active-high), bus (slave modport); ROTATE_EN adds bus.rot.
module nbit_shift_register #(
  parameter int N  = 8,
  parameter int AW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nbit_shift_register_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          dir_l;
  logic [N-1:0]  q_r;
  logic          done_r;

  logic          in_r;
  logic          in_l;
  logic [N-1:0]  shr;
  logic [N-1:0]  shl;
  logic          is_shift;

`ifdef ROTATE_EN
  assign in_r = bus.rot ? q_r[0]   : bus.sin;
  assign in_l = bus.rot ? q_r[N-1] : bus.sin;
`else
  assign in_r = bus.sin;
  assign in_l = bus.sin;
`endif

  assign shr      = {in_r, q_r[N-1:1]};
  assign shl      = {q_r[N-2:0], in_l};
  assign is_shift = (bus.mode == 2'b01)
                 || (bus.mode == 2'b10);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_l  <= 1'b0;
      q_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && is_shift) begin
          // q holds on the start edge
          if (bus.amt == '0) begin
            done_r <= 1'b1;
          end else begin
            dir_l <= bus.mode[1];
            cnt   <= bus.amt;
            state <= BUSY;
          end
        end else begin
          unique case (1'b1)
            bus.mode == 2'b01: q_r <= shr;
            bus.mode == 2'b10: q_r <= shl;
            bus.mode == 2'b11: q_r <= bus.data;
            default:           q_r <= q_r;
          endcase
        end
      end else begin
        q_r <= dir_l ? shl : shr;
        cnt <= cnt - AW'(1);
        if (cnt == AW'(1)) begin
          state  <= IDLE;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.q      = q_r;
  assign bus.sout_r = q_r[0];
  assign bus.sout_l = q_r[N-1];
  assign bus.busy   = (state == BUSY);
  assign bus.done   = done_r;

endmodule

// File: tb/tb_nbit_shift_register.sv
// Testbench for nbit_shift_register (N=8, AW=4).
// Directed steps then random stimulus against a queue-based reference model.
module tb_nbit_shift_register;

  localparam int N  = 8;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nbit_shift_register_if #(.N(N), .AW(AW)) bus ();

  nbit_shift_register #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mq;
  bit         mdone;
  bit         pend[$];

  function automatic logic [7:0] do_shift(
    input logic [7:0] v,
    input bit         left,
    input logic       s,
    input logic       r
  );
    logic b;
    if (left) begin
      b = r ? v[7] : s;
      return 8'((v * 2) + b);
    end
    b = r ? v[0] : s;
    return 8'((v / 2) + (b ? 128 : 0));
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit   nd;
    bit   d;
    logic r;
    int   m;
    nd = 0;
    r  = 1'b0;
`ifdef ROTATE_EN
    r = bus.rot;
`endif
    m = int'(bus.mode);
    if (rst) begin
      mq = 8'h00;
      pend.delete();
    end else if (pend.size() > 0) begin
      d  = pend.pop_front();
      mq = do_shift(mq, d, bus.sin, r);
      if (pend.size() == 0) nd = 1;
    end else if (bus.start && (m == 1 || m == 2)) begin
      if (bus.amt == 0) nd = 1;
      else repeat (int'(bus.amt)) pend.push_back(m == 2);
    end else begin
      if (m == 1) mq = do_shift(mq, 0, bus.sin, r);
      if (m == 2) mq = do_shift(mq, 1, bus.sin, r);
      if (m == 3) mq = bus.data;
    end
    mdone = nd;
    @(posedge clk);
    #1;
    chk("q", 32'(bus.q), 32'(mq));
    chk("sout_r", 32'(bus.sout_r), 32'(mq[0]));
    chk("sout_l", 32'(bus.sout_l), 32'(mq[7]));
    chk("busy", 32'(bus.busy), 32'(pend.size() != 0));
    chk("done", 32'(bus.done), 32'(mdone));
  endtask

  task automatic drive(
    input logic       r,
    input logic [1:0] m,
    input logic [7:0] dt,
    input logic       s,
    input logic       st,
    input logic [3:0] a
  );
    rst       = r;
    bus.mode  = m;
    bus.data  = dt;
    bus.sin   = s;
    bus.start = st;
    bus.amt   = a;
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef ROTATE_EN
    bus.rot = 1'b0;
`endif
    // reset overrides a load
    drive(1, 2'b11, 8'hFF, 0, 0, 0);
    tick();
    tick();
    chk("rst_q", 32'(bus.q), 32'h00);

    // load then hold
    drive(0, 2'b11, 8'hB4, 0, 0, 0);
    tick();
    drive(0, 2'b00, 8'h00, 0, 0, 0);
    repeat (3) tick();
    chk("hold_q", 32'(bus.q), 32'hB4);

    // 3-shift right sequence
    drive(0, 2'b01, 8'h00, 0, 1, 3);
    tick();
    drive(0, 2'b00, 8'h00, 0, 0, 0);
    tick();
    chk("seq1", 32'(bus.q), 32'h5A);
    tick();
    chk("seq2", 32'(bus.q), 32'h2D);
    tick();
    chk("seq3", 32'(bus.q), 32'h16);
    chk("seq_done", 32'(bus.done), 32'h1);
    tick();

    // single left shift with sin=1
    drive(0, 2'b11, 8'hAF, 0, 0, 0);
    tick();
    drive(0, 2'b10, 8'h00, 1, 0, 0);
    tick();
    chk("shl_q", 32'(bus.q), 32'h5F);

    // reset aborts a sequence
    drive(0, 2'b01, 8'h00, 1, 1, 5);
    tick();
    drive(0, 2'b00, 8'h00, 1, 0, 0);
    tick();
    tick();
    drive(1, 2'b00, 8'h00, 1, 0, 0);
    tick();
    chk("abort_q", 32'(bus.q), 32'h00);
    drive(0, 2'b00, 8'h00, 1, 0, 0);
    tick();

    // amt=0 start
    drive(0, 2'b11, 8'h3C, 0, 0, 0);
    tick();
    drive(0, 2'b10, 8'h00, 1, 1, 0);
    tick();
    chk("amt0_done", 32'(bus.done), 32'h1);
    chk("amt0_q", 32'(bus.q), 32'h3C);
    drive(0, 2'b00, 8'h00, 0, 0, 0);
    tick();

    // amt > N, start during BUSY dropped, back-to-back
    drive(0, 2'b10, 8'h00, 1, 1, 12);
    tick();
    drive(0, 2'b01, 8'hAA, 0, 1, 2);
    repeat (12) tick();
    drive(0, 2'b01, 8'h00, 0, 1, 2);
    repeat (3) tick();

`ifdef ROTATE_EN
    drive(0, 2'b11, 8'h81, 0, 0, 0);
    tick();
    bus.rot = 1'b1;
    drive(0, 2'b01, 8'h00, 0, 1, 1);
    tick();
    drive(0, 2'b00, 8'h00, 0, 0, 0);
    tick();
    chk("rot_q", 32'(bus.q), 32'hC0);
    chk("rot_done", 32'(bus.done), 32'h1);
    bus.rot = 1'b0;
`endif

    // random phase
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0),
            2'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)));
`ifdef ROTATE_EN
      bus.rot = 1'($urandom);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nbit_shift_register.md
NBIT_SHIFT_REGISTER -- requirements
Module: nbit_shift_register

Interface
REQ-001 SHALL have parameter N, default 8, meaning register width in bits (N >= 2).
REQ-002 SHALL have parameter AW, default 4, meaning shift-amount width; AW >= clog2(N+1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port data, input, N, parallel load value.
REQ-006 SHALL have port mode, input, 2; 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port sin, input, 1, serial bit shifted into the vacated end.
REQ-008 SHALL have port start, input, 1, begins a multi-cycle shift sequence.
REQ-009 SHALL have port amt, input, AW, number of single-bit shifts in the sequence.
REQ-010 SHALL have port q, output, N, register contents.
REQ-011 SHALL have port sout_r, output, 1, equal to q[0]; combinational.
REQ-012 SHALL have port sout_l, output, 1, equal to q[N-1]; combinational.
REQ-013 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a sequence completes.

Function
REQ-015 SHALL implement two states, IDLE and BUSY, plus a down-counter cnt of AW bits.
REQ-016 In IDLE with start=0, or start=1 with mode 00/11: one op per edge: 00 q unchanged; 11 q<=data.
REQ-017 Mode 01 SHALL give q<={sin,q[N-1:1]}; mode 10 SHALL give q<={q[N-2:0],sin}.
REQ-018 In IDLE with start=1, mode 01/10, amt>0: SHALL latch direction, load cnt<=amt, enter BUSY; q unchanged that edge.
REQ-019 In BUSY each edge SHALL shift once in the latched direction using current sin, cnt<=cnt-1.
REQ-020 The edge on which cnt==1 SHALL perform the last shift, return to IDLE, set done=1 for exactly one cycle.
REQ-021 Latency: amt shifts complete in amt cycles after the start edge; done visible with the final q.
REQ-022 start with amt=0 and mode 01/10 SHALL leave q unchanged, stay IDLE, pulse done next cycle.
REQ-023 In BUSY, mode, data, amt, start SHALL be ignored; a start during BUSY is dropped, not queued.
REQ-024 amt > N SHALL still perform amt shifts (no saturation or modulo).
REQ-025 busy SHALL be 1 exactly in BUSY; done SHALL be 0 in all other cycles.
REQ-026 A new start is accepted in the cycle after done (back-to-back allowed).

Reset
REQ-027 rst=1 at an edge SHALL override all inputs: q=0, cnt=0, state IDLE, busy=0, done=0.
REQ-028 rst during BUSY SHALL abort the sequence with no done pulse.

Configuration
REQ-029 Macro ROTATE_EN: when defined, an input rot (1 bit) SHALL exist; rot=1 makes shifts rotate (bit shifted out re-enters, sin ignored).
REQ-030 rot SHALL be sampled per shift edge, including inside BUSY.
REQ-031 Without ROTATE_EN, port rot SHALL be absent and all shifts use sin.

Verification (N=8, AW=4)
REQ-032 rst=1 two cycles, mode=11, data=8'hFF -> q=8'h00, busy=0, done=0.
REQ-033 mode=11 data=8'hB4 one edge, then mode=00 three edges -> q=8'hB4 throughout.
REQ-034 q=8'hB4, mode=01, sin=0, start=1, amt=3 -> busy 3 cycles, q=5A,2D,16, done=1 with q=16.
REQ-035 q=8'hAF, mode=10, sin=1, start=0 -> q=8'h5F after one edge; busy/done stay 0.
REQ-036 start, amt=5, mode=01; rst=1 after 2 shifts -> q=00, busy=0, no done; amt=0 start -> done one cycle later, q unchanged.
REQ-037 ROTATE_EN defined: q=8'h81, mode=01, rot=1, start, amt=1 -> q=8'hC0, done=1.
